// File: rtl/e603_gnrl_clkgate_ctrl_pkg.sv
// Shared definitions for the general-purpose clock-gate enable controller.
// Holds the state encoding and the default thresholds, so every per-unit
// instantiation uses the same values.
package e603_gnrl_clkgate_ctrl_pkg;

    // State encoding
    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] GATED = 2'd1;
    localparam logic [1:0] WAKE  = 2'd2;

    typedef enum logic [1:0] {
        StRun   = RUN,
        StGated = GATED,
        StWake  = WAKE
    } clkgate_state_e;

    // Defaults shared by all gated domains
    localparam int unsigned DEFAULT_IDLE_THRESH = 8;
    localparam int unsigned DEFAULT_WAKE_LAT    = 2;
    localparam int unsigned DEFAULT_CNT_W       = 4;

endpackage

// File: rtl/e603_gnrl_clkgate_ctrl.sv
// Enable-side controller for the general-purpose clock-gate cell.
// Runs on the free-running clock. It watches one gated unit and drops clock_en
// after IDLE_THRESH consecutive idle cycles. On a wake request it restores
// clock_en and acknowledges once the clock has run for WAKE_LAT cycles.
//
// Ports:
//   clk               free-running clock (never the gated clock)
//   rst_n             asynchronous active-low reset
//   test_mode_i       DFT mode, forces the gate transparent through bypass
//   cg_disable_i      software force-on, inhibits gating
//   unit_busy_i       activity indication from the gated unit
//   wake_req_i        level request, held until wake_ack_o
//   wake_ack_o        single-cycle pulse: clock is running and settled
//   clock_en_o        registered enable to the clock-gate cell
//   clkgate_bypass_o  bypass to the clock-gate cell (= test_mode_i)
//   gated_o           status, high while in GATED
module e603_gnrl_clkgate_ctrl
    import e603_gnrl_clkgate_ctrl_pkg::*;
#(
    parameter int unsigned IDLE_THRESH = DEFAULT_IDLE_THRESH,
    parameter int unsigned WAKE_LAT    = DEFAULT_WAKE_LAT,
    parameter int unsigned CNT_W       = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic test_mode_i,
    input  logic cg_disable_i,
    input  logic unit_busy_i,
    input  logic wake_req_i,
    output logic wake_ack_o,
    output logic clock_en_o,
    output logic clkgate_bypass_o,
    output logic gated_o
);

    localparam logic [CNT_W-1:0] IdleLast = CNT_W'(IDLE_THRESH - 1);
    localparam logic [CNT_W-1:0] WakeLast = CNT_W'(WAKE_LAT - 1);
    localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

    if ((IDLE_THRESH < 1) || (IDLE_THRESH > (2 ** CNT_W) - 1)) begin : g_bad_idle_thresh
        $error("IDLE_THRESH out of range 1..2^CNT_W-1");
    end
    if ((WAKE_LAT < 1) || (WAKE_LAT > 2 ** CNT_W)) begin : g_bad_wake_lat
        $error("WAKE_LAT out of range");
    end

    clkgate_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             clock_en_q, clock_en_d;
    logic             wake_ack_q, wake_ack_d;
    logic             gated_q, gated_d;
    logic             idle;
    logic             wake_cond;

    assign idle      = ~unit_busy_i & ~wake_req_i & ~cg_disable_i;
    assign wake_cond = wake_req_i | cg_disable_i | unit_busy_i;
    // The counter saturates rather than wrapping. Legal parameters never reach the limit.
    assign cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wake_ack_d = 1'b0;
        clock_en_d = 1'b1;
        unique case (state_q)
            StRun: begin
                if (idle) begin
                    if (cnt_q == IdleLast) begin
                        state_d = StGated;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    cnt_d = '0;
                end
                // The ack just issued blocks one cycle, so a held req is not acked twice.
                wake_ack_d = wake_req_i & ~wake_ack_q;
            end
            StGated: begin
                // The enable drops only after one full cycle in GATED. It rises on
                // the same edge that leaves GATED.
                if (wake_cond) begin
                    state_d = StWake;
                    cnt_d   = '0;
                end else begin
                    clock_en_d = 1'b0;
                end
            end
            StWake: begin
                if (cnt_q == WakeLast) begin
                    state_d    = StRun;
                    cnt_d      = '0;
                    wake_ack_d = wake_req_i;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase
        gated_d = (state_d == StGated);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            cnt_q      <= '0;
            clock_en_q <= 1'b1;
            wake_ack_q <= 1'b0;
            gated_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clock_en_q <= clock_en_d;
            wake_ack_q <= wake_ack_d;
            gated_q    <= gated_d;
        end
    end

    assign clock_en_o       = clock_en_q;
    assign wake_ack_o       = wake_ack_q;
    assign gated_o          = gated_q;
    assign clkgate_bypass_o = test_mode_i;

endmodule

// File: tb/tb_e603_gnrl_clkgate_ctrl.sv
// Directed bench for e603_gnrl_clkgate_ctrl with default parameters
// (IDLE_THRESH=8, WAKE_LAT=2). A vector table covers the main sequence.
// Hand-written sequences cover reset, bypass and the multi-cycle corner cases.
module tb_e603_gnrl_clkgate_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic test_mode = 1'b0, cg_disable = 1'b0, unit_busy = 1'b0, wake_req = 1'b0;
    logic wake_ack, clock_en, clkgate_bypass, gated;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic busy, req, cgd, tm;
        logic en, ack, g;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    e603_gnrl_clkgate_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .test_mode_i      (test_mode),
        .cg_disable_i     (cg_disable),
        .unit_busy_i      (unit_busy),
        .wake_req_i       (wake_req),
        .wake_ack_o       (wake_ack),
        .clock_en_o       (clock_en),
        .clkgate_bypass_o (clkgate_bypass),
        .gated_o          (gated)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic en, input logic ack, input logic g);
        chk({tag, " clock_en"}, clock_en, en);
        chk({tag, " wake_ack"}, wake_ack, ack);
        chk({tag, " gated"}, gated, g);
    endtask

    // Sample 1 time unit after the active edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic b, input logic r, input logic d, input logic t);
        unit_busy  = b;
        wake_req   = r;
        cg_disable = d;
        test_mode  = t;
    endtask

    function automatic void add(input logic b, input logic r, input logic d, input logic t,
                                input logic en, input logic ack, input logic g);
        vec_t v;
        v.busy = b; v.req = r; v.cgd = d; v.tm = t;
        v.en = en; v.ack = ack; v.g = g;
        vecs.push_back(v);
    endfunction

    // Idle rows that end in gating: n-1 rows stay ungated, then gated rises, then clock_en falls.
    function automatic void add_gate_run(input int n, input logic tm_alt);
        for (int k = 1; k < n; k++) add(0, 0, 0, tm_alt & k[0], 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 0, tm_alt, 0, 0, 1);
    endfunction

    task automatic reset_with_random(input string tag);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            step();
            chk_out($sformatf("%s reset cyc%0d", tag, i), 1, 0, 0);
        end
        drive(0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        // Main sequence, one row per edge after reset release.
        // Gating with test_mode toggling must leave the FSM timing unchanged.
        add_gate_run(8, 1'b1);
        add(0, 0, 0, 0, 0, 0, 1);
        // Wake from GATED: enable at +1, ack at +3, req held through the ack cycle
        add(0, 1, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 1, 0);
        add(0, 1, 0, 0, 1, 0, 0);
        add_gate_run(8, 1'b0);
        // cg_disable in GATED: wake with no ack, then stay ungated
        for (int k = 0; k < 7; k++) add(0, 0, 1, 0, 1, 0, 0);
        add_gate_run(8, 1'b0);
        // Busy wakes the clock with no ack. Then a 2-cycle req in RUN gives a single ack.
        for (int k = 0; k < 3; k++) add(1, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 1, 0);
        add(0, 1, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0);
        // Busy in the terminal idle cycle blocks gating and restarts the count
        add(1, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 7; k++) add(0, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0);
        add_gate_run(8, 1'b0);

        // Bypass is combinational within the cycle
        test_mode = 1'b1;
        #1 chk("bypass rise", clkgate_bypass, 1'b1);
        test_mode = 1'b0;
        #1 chk("bypass fall", clkgate_bypass, 1'b0);

        reset_with_random("r1");
        chk_out("post-release", 1, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].busy, vecs[i].req, vecs[i].cgd, vecs[i].tm);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].en, vecs[i].ack, vecs[i].g);
            chk($sformatf("vec%0d bypass", i), clkgate_bypass, vecs[i].tm);
        end

        // Reset asserted in WAKE, one edge before the ack would have appeared
        drive(0, 1, 0, 0);
        step();
        chk_out("wake1", 1, 0, 0);
        step();
        chk_out("wake2", 1, 0, 0);
        rst_n = 1'b0;
        #1 chk_out("async reset in WAKE", 1, 0, 0);
        step();
        chk_out("held reset", 1, 0, 0);
        drive(0, 0, 0, 0);
        rst_n = 1'b1;

        // wake_req on the terminal idle cycle: no gating, RUN ack instead
        for (int k = 0; k < 7; k++) begin
            step();
            chk_out($sformatf("term idle%0d", k), 1, 0, 0);
        end
        wake_req = 1'b1;
        step();
        chk_out("term req", 1, 1, 0);
        wake_req = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk_out($sformatf("regate idle%0d", k), 1, 0, 0);
        end
        step();
        chk_out("regate gated", 1, 0, 1);
        step();
        chk_out("regate en low", 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/e603_gnrl_clkgate_ctrl.md
Name: e603_gnrl_clkgate_ctrl

Overview:
Enable-side controller for the general-purpose clock-gate cell. It runs on the free-running (ungated) clock and watches activity from one gated unit. After a programmable number of consecutive idle cycles it drops clock_en. On a wake request it restores clock_en, then acknowledges the requester once the gated clock has been running for a settle interval. It also drives the cell's bypass input from test mode.

Parameters:
IDLE_THRESH, 8, consecutive idle cycles before gating (legal range 1..2^CNT_W-1)
WAKE_LAT, 2, ungated cycles clock_en stays high before wake_ack or return to RUN (>=1)
CNT_W, 4, width of the shared idle/wake counter

Ports:
clk  in  1  free-running clock (never the gated clock)
rst_n  in  1  asynchronous active-low reset
test_mode  in  1  DFT mode; forces the gate transparent
cg_disable  in  1  software force-on; inhibits gating
unit_busy  in  1  activity indication from the gated unit
wake_req  in  1  level request to have the clock running; held until wake_ack
wake_ack  out  1  single-cycle pulse: the clock is running and settled
clock_en  out  1  to the clock-gate cell enable; registered
clkgate_bypass  out  1  to the clock-gate cell bypass
gated  out  1  status, high while in GATED

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
- Reset values: state=RUN, cnt=0, clock_en=1, wake_ack=0, gated=0. Reset asserted mid-operation returns to these values immediately, whatever the state.
- clkgate_bypass = test_mode, combinational. It is the only combinational path to an output. The FSM runs unchanged in test mode.
- idle = !unit_busy & !wake_req & !cg_disable.
- clock_en, wake_ack and gated are flop outputs. There is no combinational path from any input to these outputs, so the enable seen by the gate's latch is glitch-free.
- RUN (clock_en=1):
  - If idle: cnt increments.
  - If !idle: cnt clears to 0.
  - If idle and cnt==IDLE_THRESH-1: go to GATED and clear cnt. clock_en is 0 from the next edge.
  - Net effect: idle sampled on IDLE_THRESH consecutive edges, then clock_en falls at the following edge.
  - wake_req high in RUN: wake_ack=1 on the next cycle (latency 1). Gating is blocked because wake_req makes idle false.
- GATED (clock_en=0, gated=1): if wake_req | cg_disable | unit_busy, go to WAKE with cnt=0. clock_en is 1 at the next edge.
- WAKE (clock_en=1): cnt increments each cycle.
  - When cnt==WAKE_LAT-1: go to RUN and clear cnt.
  - If wake_req is high in that cycle, wake_ack pulses on the same transition edge.
  - Result: from wake_req sampled in GATED to wake_ack high is WAKE_LAT+1 cycles.
- Handshake rules:
  - wake_ack is always exactly one cycle wide.
  - After an ack, ack is suppressed for one cycle, so a req still high in the ack cycle does not re-ack.
  - The requester deasserts req in the cycle after ack.
  - wake_req that drops before ack (illegal) aborts nothing: WAKE completes and no ack is issued.
- Simultaneous events:
  - wake_req or busy arriving in the terminal idle cycle: no gating; cnt clears.
  - cg_disable rising in WAKE: WAKE completes, then RUN holds ungated.
  - cg_disable in GATED: wakes the clock like wake_req but produces no ack.
- cnt saturates rather than wrapping; this is unreachable under legal parameters. A parameter check errors in simulation if IDLE_THRESH or WAKE_LAT is out of range.

Decomposition:
- Shared package: the state encoding localparams (RUN=2'd0, GATED=2'd1, WAKE=2'd2) and the default IDLE_THRESH/WAKE_LAT constants, so the per-unit instantiations agree.
- Single module; no sub-module needed.
- Top level: the controller pairs with one clock-gate cell instance per gated domain. clock_en and clkgate_bypass connect directly to the cell, with no logic between them.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with random inputs -> clock_en=1, wake_ack=0, gated=0. Release -> still RUN.
2. Gating: defaults, all inputs 0 after reset -> clock_en falls exactly at the 9th edge after release, and gated=1. Pulse unit_busy at idle cycle 7 -> cnt clears, and gating occurs 8 idle cycles later.
3. Wake from GATED: raise wake_req -> clock_en=1 at edge +1. wake_ack is a one-cycle pulse at edge +3 (WAKE_LAT=2). Requester drops req -> stays RUN, and re-gates after 8 idle cycles.
4. Wake in RUN: wake_req for 2 cycles -> single ack at +1. Req held through the ack cycle -> no second ack.
5. cg_disable: assert in GATED -> clock_en=1 with no ack, and clock_en stays high indefinitely. Deassert -> gates after 8 idle cycles.
6. test_mode toggle -> clkgate_bypass follows in the same cycle, while the FSM sequence of test 2 is unchanged. Assert rst_n low in WAKE -> clock_en=1 and wake_ack=0 immediately.
